serial_tx_framer: RTL

Transmit-side serializer that feeds the receive physical layer's serial input. It takes parallel bytes through a valid/ready handshake and sends them MSB-first, one bit per clk_32f cycle. After reset it emits a fixed number of COM alignment symbols so the downstream serial-to-parallel stage can lock. Whenever no byte is pending, it fills the line with COM symbols.

---
 rtl/serial_tx_framer_pkg.sv | 14 +
 rtl/serial_tx_framer_if.sv | 23 ++
 rtl/serial_tx_framer_tx_shifter.sv | 61 ++++++
 rtl/serial_tx_framer.sv | 75 +++++++
 4 files changed

// File: rtl/serial_tx_framer_pkg.sv
// Shared constants for the transmit framer and the matching receiver:
// the COM idle/alignment symbol, default alignment length and FSM states.
package serial_tx_framer_pkg;

  localparam int         DEF_WIDTH       = 8;
  localparam logic [7:0] DEF_COM_SYMBOL  = 8'hBC;
  localparam int         DEF_ALIGN_COUNT = 4;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } tx_state_e;

endpackage

// File: rtl/serial_tx_framer_if.sv
// Byte-wide valid/ready handshake between the upstream source (master)
// and the serial framer (slave).
interface serial_tx_framer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );

endinterface

// File: rtl/serial_tx_framer_tx_shifter.sv
// Symbol shifter: walks the current symbol MSB-first, one bit per clock,
// and picks the next symbol (loaded byte or COM) at each symbol boundary.
module serial_tx_framer_tx_shifter
  import serial_tx_framer_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] COM_SYMBOL = DEF_COM_SYMBOL
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_boundary,
  output logic             o_serial,
  output logic             o_sending
);

  localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LASTIDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ONE     = CW'(1);

  logic [WIDTH-1:0] r_sym;
  logic             r_is_data;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_serial;
  logic             r_sending;
  logic             w_boundary;

  assign w_boundary = (r_bit_cnt == LASTIDX);
  assign o_boundary = w_boundary;
  assign o_serial   = r_serial;
  assign o_sending  = r_sending;

  // Output bit and the data flag are both taken from the pre-edge symbol,
  // so sending_data stays aligned with the bit it qualifies.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sym     <= COM_SYMBOL;
      r_is_data <= 1'b0;
      r_bit_cnt <= '0;
      r_serial  <= 1'b0;
      r_sending <= 1'b0;
    end else begin
      r_serial  <= r_sym[LASTIDX - r_bit_cnt];
      r_sending <= r_is_data;
      if (w_boundary) begin
        r_bit_cnt <= '0;
        if (i_load) begin
          r_sym     <= i_load_data;
          r_is_data <= 1'b1;
        end else begin
          r_sym     <= COM_SYMBOL;
          r_is_data <= 1'b0;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/serial_tx_framer.sv
// Transmit framer top: one-entry holding buffer, valid/ready handshake and
// the ALIGN/RUN sequencer that sends COM symbols until the link is aligned.
module serial_tx_framer
  import serial_tx_framer_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] COM_SYMBOL  = DEF_COM_SYMBOL,
  parameter int               ALIGN_COUNT = DEF_ALIGN_COUNT
) (
  input  logic                clk_32f,
  input  logic                rst,
  serial_tx_framer_if.slave   bus,
  output logic                serial_out,
  output logic                sending_data,
  output logic                aligned
);

  localparam int              CNTW     = $clog2(ALIGN_COUNT + 1);
  localparam logic [CNTW-1:0] LAST_COM = CNTW'(ALIGN_COUNT - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  tx_state_e        r_state;
  logic [CNTW-1:0]  r_com_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;

  logic w_boundary;
  logic w_ready;
  logic w_accept;
  logic w_load;

  // Ready comes only from registers, so valid_in never loops back to ready.
  assign w_ready       = (r_state == ST_RUN) && !r_hold_full;
  assign w_accept      = bus.valid_in && w_ready;
  assign w_load        = (r_state == ST_RUN) && r_hold_full && w_boundary;
  assign bus.ready_out = w_ready;
  assign aligned       = (r_state == ST_RUN);

  // Accept and load are exclusive: accept needs an empty buffer, load a full one.
  always_ff @(posedge clk_32f) begin
    if (rst) begin
      r_state     <= ST_ALIGN;
      r_com_cnt   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold      <= bus.data_in;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_boundary && (r_state == ST_ALIGN)) begin
        r_com_cnt <= r_com_cnt + CNT_ONE;
        if (r_com_cnt == LAST_COM) begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  serial_tx_framer_tx_shifter #(
    .WIDTH      (WIDTH),
    .COM_SYMBOL (COM_SYMBOL)
  ) u_shifter (
    .i_clk       (clk_32f),
    .i_rst       (rst),
    .i_load      (w_load),
    .i_load_data (r_hold),
    .o_boundary  (w_boundary),
    .o_serial    (serial_out),
    .o_sending   (sending_data)
  );

endmodule
